jt900h_muldiv: RTL and testbench

JT900H_MULDIV -- requirements
Module: jt900h_muldiv

---
 rtl/jt900h_muldiv.sv | 128 ++++++++++++
 tb/tb_jt900h_muldiv.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_muldiv.sv
// jt900h_muldiv: sequential radix-2 multiply/divide, unsigned or signed, half or full width.
// Signed operands are reduced to magnitudes up front; signs are reapplied in FIX.
module jt900h_muldiv #(
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cen,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic            w,
   input  logic [2*DW-1:0] op0,
   input  logic [DW-1:0]   op1,
   output logic            busy,
   output logic            done,
   output logic [2*DW-1:0] dout,
   output logic            ovf
);
   localparam int HW = DW/2;
   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t state, state_n;

   logic [CW-1:0]   cnt;
   logic [2*DW-1:0] acc;
   logic [DW-1:0]   b, mq;
   logic            is_div, sgn, neg, rneg, wr, early_r;

   logic [DW-1:0]   mask_n, a_lo, b_in, a_mag, b_mag, d_hi, d_lo;
   logic [2*DW-1:0] mask_2n, d_in, d_mag, early_val;
   logic            s_a, s_b, early, accept;

   // Short operands are zero-extended; the multiplier and the low dividend half are
   // left-aligned so every step consumes bit DW-1 regardless of width.
   always_comb begin
      mask_n    = {{HW{w}}, {HW{1'b1}}};
      mask_2n   = {{DW{w}}, {DW{1'b1}}};
      a_lo      = op0[DW-1:0] & mask_n;
      b_in      = op1 & mask_n;
      d_in      = op0 & mask_2n;
      s_a       = op[0] & (op[1] ? (w ? op0[2*DW-1] : op0[DW-1]) : (w ? op0[DW-1] : op0[HW-1]));
      s_b       = op[0] & (w ? op1[DW-1] : op1[HW-1]);
      a_mag     = s_a ? (-a_lo) & mask_n : a_lo;
      b_mag     = s_b ? (-b_in) & mask_n : b_in;
      d_mag     = s_a ? (-d_in) & mask_2n : d_in;
      d_hi      = w ? d_mag[2*DW-1:DW] : {{HW{1'b0}}, d_mag[DW-1:HW]};
      d_lo      = w ? d_mag[DW-1:0] : {d_mag[HW-1:0], {HW{1'b0}}};
      early     = op[1] & (d_hi >= b_mag);
      early_val = b_in != '0 ? d_in :
                  w ? {op0[DW-1:0], {DW{1'b1}}} : {{DW{1'b0}}, op0[HW-1:0], {HW{1'b1}}};
      accept    = start & (state == IDLE || state == DONE);
   end

   logic [2*DW:0]   sh;
   logic [DW-1:0]   diff, qs, rs, lim, mn;
   logic [2*DW-1:0] mn2, pm, res;
   logic            ge, sovf;

   always_comb begin
      sh   = {acc, 1'b0};
      ge   = sh[2*DW:DW] >= {1'b0, b};
      diff = sh[2*DW-1:DW] - b;
      mn   = {{HW{wr}}, {HW{1'b1}}};
      mn2  = {{DW{wr}}, {DW{1'b1}}};
      qs   = neg ? (-acc[DW-1:0]) & mn : acc[DW-1:0];
      rs   = rneg ? (-acc[2*DW-1:DW]) & mn : acc[2*DW-1:DW];
      lim  = wr ? {1'b1, {DW-1{1'b0}}} : {{HW{1'b0}}, 1'b1, {HW-1{1'b0}}};
      sovf = neg ? acc[DW-1:0] > lim : acc[DW-1:0] >= lim;
      pm   = neg ? (-acc) & mn2 : acc;
      res  = early_r ? acc : !is_div ? pm :
             wr ? {rs, qs} : {{DW{1'b0}}, rs[HW-1:0], qs[HW-1:0]};
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else if (cen) state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: state_n = accept ? (early ? FIX : RUN) : IDLE;
         RUN:        state_n = cnt == '0 ? FIX : RUN;
         FIX:        state_n = DONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         b       <= '0;
         mq      <= '0;
         cnt     <= '0;
         is_div  <= 1'b0;
         sgn     <= 1'b0;
         neg     <= 1'b0;
         rneg    <= 1'b0;
         wr      <= 1'b0;
         early_r <= 1'b0;
         dout    <= '0;
         ovf     <= 1'b0;
      end else if (cen) begin
         if (accept) begin
            is_div  <= op[1];
            sgn     <= op[0];
            wr      <= w;
            neg     <= s_a ^ s_b;
            rneg    <= s_a;
            early_r <= early;
            b       <= op[1] ? b_mag : a_mag;
            mq      <= w ? b_mag : {b_mag[HW-1:0], {HW{1'b0}}};
            cnt     <= w ? CW'(DW-1) : CW'(HW-1);
            acc     <= early ? early_val : op[1] ? {d_hi, d_lo} : '0;
         end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            mq  <= mq << 1;
            acc <= is_div ? (ge ? {diff, sh[DW-1:1], 1'b1} : sh[2*DW-1:0]) :
                   sh[2*DW-1:0] + {{DW{1'b0}}, (mq[DW-1] ? b : {DW{1'b0}})};
         end else if (state == FIX) begin
            dout <= res;
            ovf  <= early_r | (is_div & sgn & sovf);
         end
      end
   end

   assign busy = state == RUN || state == FIX;
   assign done = state == DONE;
endmodule

// File: tb/tb_jt900h_muldiv.sv
// tb_jt900h_muldiv: random and directed checks of jt900h_muldiv against an arithmetic model.
module tb_jt900h_muldiv;
   localparam int DW = 16;
   logic        clk = 0, rst_n = 1, cen = 1, start = 0, w = 0;
   logic [1:0]  op = 0;
   logic [31:0] op0 = 0;
   logic [15:0] op1 = 0;
   logic        busy, done, ovf;
   logic [31:0] dout;
   int          total = 0, bad = 0;

   logic        e_busy = 0, e_done = 0, e_ovf = 0, p_ovf = 0;
   logic [31:0] e_dout = 0, p_dout = 0;
   int          rem = 0;

   jt900h_muldiv #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .op(op), .w(w),
      .op0(op0), .op1(op1), .busy(busy), .done(done), .dout(dout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Result, overflow and latency (active edges after the accepting edge) from plain arithmetic.
   task automatic ref_op(input logic [1:0] o, input logic ww, input logic [31:0] a, input logic [15:0] b,
                         output logic [31:0] d, output logic ov, output int lat);
      int n;
      longint m1, m2, half, x, y, dd, bb, q, r;
      n    = ww ? 16 : 8;
      m1   = (64'sd1 << n) - 1;
      m2   = (64'sd1 << (2*n)) - 1;
      half = (m1 + 1) / 2;
      ov   = 0;
      lat  = n + 1;
      if (!o[1]) begin
         x = a & m1;
         y = b & m1;
         if (o[0] && x >= half) x -= m1 + 1;
         if (o[0] && y >= half) y -= m1 + 1;
         d = 32'((x * y) & m2);
      end else begin
         dd = a & m2;
         bb = b & m1;
         if (o[0] && dd >= (m2 + 1) / 2) dd -= m2 + 1;
         if (o[0] && bb >= half) bb -= m1 + 1;
         if (bb == 0) begin
            ov = 1; lat = 1;
            d = 32'(((a & m1) << n) | m1);
         end else if (((dd < 0 ? -dd : dd) >> n) >= (bb < 0 ? -bb : bb)) begin
            ov = 1; lat = 1;
            d = 32'(a & m2);
         end else begin
            q = dd / bb;
            r = dd % bb;
            if (o[0] && (q < -half || q > half - 1)) ov = 1;
            d = 32'(((r & m1) << n) | (q & m1));
         end
      end
   endtask

   task automatic pin(input string nm, input logic [1:0] o, input logic ww, input logic [31:0] a,
                      input logic [15:0] b, input logic [31:0] ed, input logic eo, input int el);
      logic [31:0] d;
      logic        ov;
      int          lat;
      ref_op(o, ww, a, b, d, ov, lat);
      chk({nm, "_mdout"}, d, ed);
      chk({nm, "_movf"}, {31'b0, ov}, {31'b0, eo});
      chk({nm, "_mlat"}, lat, el);
   endtask

   // Expected busy/done/dout/ovf advanced once per active edge.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         e_busy = 0; e_done = 0; e_ovf = 0; e_dout = 0; rem = 0;
      end else if (cen) begin
         e_done = 0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               e_done = 1; e_dout = p_dout; e_ovf = p_ovf;
            end
         end else if (start) ref_op(op, w, op0, op1, p_dout, p_ovf, rem);
         e_busy = rem > 0;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("done", {31'b0, done}, {31'b0, e_done});
      chk("dout", dout, e_dout);
      chk("ovf", {31'b0, ovf}, {31'b0, e_ovf});
   end

   task automatic run_op(input string nm, input logic [1:0] o, input logic ww, input logic [31:0] a,
                         input logic [15:0] b, input logic [31:0] ed, input logic eo, input int el,
                         input logic stall);
      int n;
      @(posedge clk); #3;
      start = 1; op = o; w = ww; op0 = a; op1 = b;
      @(posedge clk); #3;
      start = 0;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
         if (stall && n == 2) begin cen = 0; start = 1; op = ~o; op0 = ~a; end
         if (stall && n == 7) cen = 1;
         if (stall && n == 9) start = 0;
      end while (!done && n < 200);
      chk({nm, "_lat"}, n, el);
      chk({nm, "_dout"}, dout, ed);
      chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
      @(posedge clk); #1;
      chk({nm, "_pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      pin("p031", 2'd0, 0, 32'h000000FF, 16'h00FF, 32'h0000FE01, 0, 9);
      pin("p032", 2'd1, 1, 32'h0000FFFF, 16'h0002, 32'hFFFFFFFE, 0, 17);
      pin("p033a", 2'd2, 1, 32'h00010005, 16'h0002, 32'h00018002, 0, 17);
      pin("p033b", 2'd3, 0, 32'h0000FFF9, 16'h0002, 32'h0000FFFD, 0, 9);
      pin("p034a", 2'd2, 0, 32'h00001234, 16'h0000, 32'h000034FF, 1, 1);
      pin("p034b", 2'd2, 0, 32'h00000500, 16'h0003, 32'h00000500, 1, 1);
      pin("psovf", 2'd3, 0, 32'h00000080, 16'h0001, 32'h00000080, 1, 9);

      #1 rst_n = 0;
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_dout", dout, 32'd0);
      chk("rst_ovf", {31'b0, ovf}, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1;

      run_op("r031", 2'd0, 0, 32'h000000FF, 16'h00FF, 32'h0000FE01, 0, 9, 0);
      run_op("r032", 2'd1, 1, 32'h0000FFFF, 16'h0002, 32'hFFFFFFFE, 0, 17, 0);
      run_op("r033a", 2'd2, 1, 32'h00010005, 16'h0002, 32'h00018002, 0, 17, 0);
      run_op("r033b", 2'd3, 0, 32'h0000FFF9, 16'h0002, 32'h0000FFFD, 0, 9, 0);
      run_op("r034a", 2'd2, 0, 32'h00001234, 16'h0000, 32'h000034FF, 1, 1, 0);
      run_op("r034b", 2'd2, 0, 32'h00000500, 16'h0003, 32'h00000500, 1, 1, 0);
      run_op("rsovf", 2'd3, 0, 32'h00000080, 16'h0001, 32'h00000080, 1, 9, 0);
      run_op("rsneg", 2'd3, 0, 32'h0000FF80, 16'h0001, 32'h00000080, 0, 9, 0);
      run_op("rmmin", 2'd1, 0, 32'h00000080, 16'h0080, 32'h00004000, 0, 9, 0);
      run_op("rsbig", 2'd3, 1, 32'hFFFF0000, 16'h0001, 32'hFFFF0000, 1, 1, 0);
      run_op("rstall", 2'd0, 0, 32'h000000FF, 16'h00FF, 32'h0000FE01, 0, 14, 1);

      @(posedge clk); #3;
      start = 1; op = 2'd2; w = 1; op0 = 32'h00010005; op1 = 16'h0002;
      @(posedge clk); #3;
      start = 0;
      repeat (4) @(posedge clk);
      #1 rst_n = 0;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_dout", dout, 32'd0);
      chk("abort_ovf", {31'b0, ovf}, 32'd0);
      @(posedge clk); #3 rst_n = 1;
      run_op("rafter", 2'd0, 1, 32'h00001234, 16'h0100, 32'h00123400, 0, 17, 0);

      repeat (4000) begin
         @(posedge clk); #3;
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 0;
            @(posedge clk); #3;
            rst_n = 1;
         end
         cen   = $urandom_range(0, 9) != 0;
         start = $urandom_range(0, 3) == 0;
         op    = 2'($urandom);
         w     = 1'($urandom);
         op1   = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       op1 = 16'h0000;
            1, 2:    op1 = 16'($urandom_range(1, 15));
            default: ;
         endcase
         op0 = $urandom;
         if ($urandom_range(0, 1) == 1)
            op0 = w ? op0 >> $urandom_range(1, 31) : {op0[31:16], op0[15:0] >> $urandom_range(1, 15)};
         if ($urandom_range(0, 3) == 0) op0 = -op0;
      end
      start = 0;
      cen = 1;
      repeat (40) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
